remote_update_responder: RTL and testbench
==========================================

Name: remote_update_responder

Overview:
- Responder end of the write/busy/reconfig remote-update handshake. The existing initiator drives `write` and `reconfig` and waits on `busy`.
- Holds the remote-update parameter registers: page address, watchdog timeout, watchdog enable, config mode.
- Paces every access with a counted busy window. Issues a reconfiguration request after a delay.
- Used as the on-chip remote-update controller and as the bench-side model for initiator verification.

Parameters:
- BUSY_CYCLES, 4: cycles `busy` stays high per write/read and after reset release. Legal range ≥1.
- RECONFIG_DELAY, 8: cycles from accepted `reconfig` to `reconfig_req` assertion. Legal range ≥1.
- ADDR_WIDTH, 22: width of the page address register and of `data_in`/`data_out`.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- write  in  1  parameter-write request. Sampled only in IDLE.
- read  in  1  parameter-read request. Sampled only in IDLE.
- reconfig  in  1  reconfiguration request. Sampled only in IDLE.
- param  in  3  parameter select.
- data_in  in  ADDR_WIDTH  write data.
- busy  out  1  access in progress.
- data_out  out  ADDR_WIDTH  read data. Valid while `data_valid`=1.
- data_valid  out  1  one-cycle read-complete strobe.
- page_addr  out  ADDR_WIDTH  stored page address.
- wd_timeout  out  12  stored watchdog timeout.
- wd_en  out  1  stored watchdog enable.
- cfg_mode  out  1  stored config mode.
- reconfig_req  out  1  reconfiguration trigger. Sticky until reset.

Behaviour:
- Reset values (async, on rst_n=0):
  - busy=1, data_valid=0, reconfig_req=0.
  - data_out, page_addr, wd_timeout, wd_en, cfg_mode all 0.
  - State=STARTUP, counter=0.
- Parameter map, write data taken from the LSBs of `data_in`:
  - 3'b000: cfg_mode, data_in[0].
  - 3'b010: wd_timeout, data_in[11:0].
  - 3'b011: wd_en, data_in[0].
  - 3'b100: page_addr, data_in[ADDR_WIDTH-1:0].
  - Any other code: write is discarded; read returns 0. The busy window runs the same as for a mapped code.
- States:
  - STARTUP: busy=1. Counts BUSY_CYCLES clocks after reset release, then goes to IDLE with busy=0. busy therefore falls on the BUSY_CYCLES-th rising edge after rst_n rises.
  - IDLE: busy=0. Request priority is reconfig > write > read.
    - reconfig=1 → RECONFIG_WAIT.
    - write=1 → WRITE_BUSY; param and data_in are captured on the same edge.
    - read=1 → READ_BUSY; param is captured on the same edge.
    - busy goes to 1 on the edge that accepts the request.
  - WRITE_BUSY: busy=1 for exactly BUSY_CYCLES cycles. On the final edge the captured value is written to the selected register, busy→0, state→IDLE. Register outputs change on the same edge that busy falls.
  - READ_BUSY: busy=1 for BUSY_CYCLES cycles. On the final edge data_out=selected register (zero-extended), data_valid=1 for one cycle, busy→0, state→IDLE.
  - RECONFIG_WAIT: busy=1. After RECONFIG_DELAY cycles, reconfig_req=1 and state→DONE.
  - DONE: busy=1 and reconfig_req=1 permanently. All inputs are ignored. Only reset exits.
- Requests arriving outside IDLE are ignored, not queued. A write held high across a busy window is re-accepted in the first IDLE cycle.
- The initiator protocol holds reconfig high continuously. The first IDLE cycle with reconfig=1 starts RECONFIG_WAIT.
- Captured param/data are not affected by input changes during a busy window.
- Reset mid-operation:
  - Any pending write is lost and registers return to 0.
  - data_valid is not emitted.
  - reconfig_req clears and STARTUP restarts.
- Counter width is clog2(max(BUSY_CYCLES, RECONFIG_DELAY))+1. The counter clears on every state entry.

Test Plan:
1. Reset release, BUSY_CYCLES=4, all inputs 0 → busy=1 for 4 cycles, then 0; all register outputs 0.
2. In IDLE: 1-cycle write, param=3'b100, data_in=22'h12345 → busy high 4 cycles; page_addr=22'h12345 on the edge busy falls; data_in changed mid-window has no effect.
3. Write wd_timeout=12'hABC, then read param=3'b010 → busy high 4 cycles, then data_valid=1 for exactly one cycle with data_out=22'h000ABC; read of param=3'b111 → data_out=0.
4. write and reconfig asserted together in IDLE → reconfig wins; busy stays 1; reconfig_req=1 after 8 cycles and remains 1 while inputs toggle for 50 cycles.
5. Second write issued while busy=1 → ignored; only the first write's value is stored.
6. rst_n pulsed low mid-WRITE_BUSY → register unchanged (0); STARTUP busy window repeats.
7. Full initiator loop with the existing state machine → observe write pulse, busy 1→0, reconfig held, reconfig_req=1 after RECONFIG_DELAY.

Source files
------------

// File: rtl/remote_update_responder.sv
// Remote-update responder: answers the write/read/reconfig handshake of an
// external initiator, holds the remote-update parameter registers, paces every
// access with a counted busy window and issues a sticky reconfiguration
// request a fixed delay after an accepted reconfig.
//
// Ports:
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   write, read      parameter write / read requests (sampled only in IDLE)
//   reconfig         reconfiguration request (sampled only in IDLE)
//   param            parameter select
//   data_in          write data (LSB-aligned)
//   busy             access or startup window in progress
//   data_out         read data, valid while data_valid is high
//   data_valid       one-cycle read-complete strobe
//   page_addr        stored page address
//   wd_timeout       stored watchdog timeout
//   wd_en            stored watchdog enable
//   cfg_mode         stored config mode
//   reconfig_req     reconfiguration trigger, sticky until reset
module remote_update_responder #(
    parameter int unsigned BUSY_CYCLES    = 4,
    parameter int unsigned RECONFIG_DELAY = 8,
    parameter int unsigned ADDR_WIDTH     = 22
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write,
    input  logic                  read,
    input  logic                  reconfig,
    input  logic [2:0]            param,
    input  logic [ADDR_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [ADDR_WIDTH-1:0] page_addr,
    output logic [11:0]           wd_timeout,
    output logic                  wd_en,
    output logic                  cfg_mode,
    output logic                  reconfig_req
);

    localparam int unsigned MAX_CYCLES = (BUSY_CYCLES > RECONFIG_DELAY) ? BUSY_CYCLES : RECONFIG_DELAY;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

    localparam logic [CNT_W-1:0] BUSY_LAST     = CNT_W'(BUSY_CYCLES - 1);
    localparam logic [CNT_W-1:0] RECONFIG_LAST = CNT_W'(RECONFIG_DELAY - 1);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);

    localparam logic [2:0] P_CFG_MODE   = 3'b000;
    localparam logic [2:0] P_WD_TIMEOUT = 3'b010;
    localparam logic [2:0] P_WD_EN      = 3'b011;
    localparam logic [2:0] P_PAGE_ADDR  = 3'b100;

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_IDLE,
        ST_WRITE_BUSY,
        ST_READ_BUSY,
        ST_RECONFIG_WAIT,
        ST_DONE
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [2:0]            cap_param;
    logic [ADDR_WIDTH-1:0] cap_data;
    logic [ADDR_WIDTH-1:0] read_value_c;

    // Read mux over the captured select; unmapped codes read as zero.
    always_comb begin
        read_value_c = '0;
        case (cap_param)
            P_CFG_MODE:   read_value_c = ADDR_WIDTH'(cfg_mode);
            P_WD_TIMEOUT: read_value_c = ADDR_WIDTH'(wd_timeout);
            P_WD_EN:      read_value_c = ADDR_WIDTH'(wd_en);
            P_PAGE_ADDR:  read_value_c = page_addr;
            default:      read_value_c = '0;
        endcase
    end

    // Handshake FSM with registered outputs; counter clears on every state entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_STARTUP;
            cnt          <= '0;
            cap_param    <= '0;
            cap_data     <= '0;
            busy         <= 1'b1;
            data_out     <= '0;
            data_valid   <= 1'b0;
            page_addr    <= '0;
            wd_timeout   <= '0;
            wd_en        <= 1'b0;
            cfg_mode     <= 1'b0;
            reconfig_req <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                ST_STARTUP: begin
                    if (cnt == BUSY_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_IDLE: begin
                    cnt <= '0;
                    if (reconfig) begin
                        state <= ST_RECONFIG_WAIT;
                        busy  <= 1'b1;
                    end else if (write) begin
                        state     <= ST_WRITE_BUSY;
                        busy      <= 1'b1;
                        cap_param <= param;
                        cap_data  <= data_in;
                    end else if (read) begin
                        state     <= ST_READ_BUSY;
                        busy      <= 1'b1;
                        cap_param <= param;
                    end
                end
                ST_WRITE_BUSY: begin
                    if (cnt == BUSY_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        case (cap_param)
                            P_CFG_MODE:   cfg_mode   <= cap_data[0];
                            P_WD_TIMEOUT: wd_timeout <= 12'(cap_data);
                            P_WD_EN:      wd_en      <= cap_data[0];
                            P_PAGE_ADDR:  page_addr  <= cap_data;
                            default:      ;
                        endcase
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_READ_BUSY: begin
                    if (cnt == BUSY_LAST) begin
                        state      <= ST_IDLE;
                        cnt        <= '0;
                        busy       <= 1'b0;
                        data_out   <= read_value_c;
                        data_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_RECONFIG_WAIT: begin
                    if (cnt == RECONFIG_LAST) begin
                        state        <= ST_DONE;
                        cnt          <= '0;
                        reconfig_req <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    // Terminal until reset; all inputs ignored.
                    busy         <= 1'b1;
                    reconfig_req <= 1'b1;
                end
                default: begin
                    state <= ST_STARTUP;
                    cnt   <= '0;
                    busy  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_remote_update_responder.sv
// Directed self-checking bench for remote_update_responder.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_remote_update_responder;

    localparam int unsigned BC = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned AW = 22;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic          reconfig = 1'b0;
    logic [2:0]    param = 3'b000;
    logic [AW-1:0] data_in = '0;
    logic          busy;
    logic [AW-1:0] data_out;
    logic          data_valid;
    logic [AW-1:0] page_addr;
    logic [11:0]   wd_timeout;
    logic          wd_en;
    logic          cfg_mode;
    logic          reconfig_req;

    int checks = 0;
    int failures = 0;

    remote_update_responder #(
        .BUSY_CYCLES(BC),
        .RECONFIG_DELAY(RD),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .write(write),
        .read(read),
        .reconfig(reconfig),
        .param(param),
        .data_in(data_in),
        .busy(busy),
        .data_out(data_out),
        .data_valid(data_valid),
        .page_addr(page_addr),
        .wd_timeout(wd_timeout),
        .wd_en(wd_en),
        .cfg_mode(cfg_mode),
        .reconfig_req(reconfig_req)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Startup window after reset release: busy high for BC edges, then low.
    task automatic release_and_startup();
        rst_n = 1'b1;
        for (int i = 1; i < int'(BC); i++) begin
            @(negedge clk);
            chk("startup_busy", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("startup_busy_fall", 32'(busy), 32'd0);
    endtask

    // One-cycle request pulse, then check busy over the whole window.
    // Returns at the falling edge after the completing rising edge.
    task automatic access(input logic w, input logic r, input logic [2:0] p, input logic [AW-1:0] d);
        write = w;
        read = r;
        param = p;
        data_in = d;
        @(negedge clk);
        write = 1'b0;
        read = 1'b0;
        for (int i = 0; i < int'(BC); i++) begin
            chk("window_busy", 32'(busy), 32'd1);
            chk("window_no_valid", 32'(data_valid), 32'd0);
            @(negedge clk);
        end
        chk("window_busy_fall", 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset values
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_req", 32'(reconfig_req), 32'd0);
        chk("rst_page", 32'(page_addr), 32'd0);
        chk("rst_wdt", 32'(wd_timeout), 32'd0);
        chk("rst_wden", 32'(wd_en), 32'd0);
        chk("rst_cfg", 32'(cfg_mode), 32'd0);
        chk("rst_dout", 32'(data_out), 32'd0);
        @(negedge clk);
        release_and_startup();

        // Page-address write; inputs changed mid-window must not matter
        write = 1'b1;
        param = 3'b100;
        data_in = 22'h12345;
        @(negedge clk);
        write = 1'b0;
        param = 3'b000;
        data_in = 22'h3FFFFF;
        for (int i = 0; i < int'(BC); i++) begin
            chk("wr_busy", 32'(busy), 32'd1);
            chk("wr_page_hold", 32'(page_addr), 32'd0);
            @(negedge clk);
        end
        chk("wr_busy_fall", 32'(busy), 32'd0);
        chk("wr_page", 32'(page_addr), 32'h12345);
        chk("wr_cfg_untouched", 32'(cfg_mode), 32'd0);

        // Timeout write and read-back, then unmapped read
        access(1'b1, 1'b0, 3'b010, 22'h3FFABC);
        chk("wdt", 32'(wd_timeout), 32'hABC);
        access(1'b0, 1'b1, 3'b010, 22'h0);
        chk("rd_valid", 32'(data_valid), 32'd1);
        chk("rd_wdt", 32'(data_out), 32'h000ABC);
        @(negedge clk);
        chk("rd_valid_one_cycle", 32'(data_valid), 32'd0);
        access(1'b0, 1'b1, 3'b111, 22'h0);
        chk("rd_unmapped_valid", 32'(data_valid), 32'd1);
        chk("rd_unmapped", 32'(data_out), 32'd0);
        access(1'b0, 1'b1, 3'b100, 22'h0);
        chk("rd_page", 32'(data_out), 32'h12345);

        // cfg_mode write, then unmapped write must change nothing
        access(1'b1, 1'b0, 3'b000, 22'h000001);
        chk("cfg", 32'(cfg_mode), 32'd1);
        access(1'b1, 1'b0, 3'b001, 22'h3FFFFF);
        chk("unm_cfg", 32'(cfg_mode), 32'd1);
        chk("unm_wdt", 32'(wd_timeout), 32'hABC);
        chk("unm_wden", 32'(wd_en), 32'd0);
        chk("unm_page", 32'(page_addr), 32'h12345);

        // Second write issued while busy is ignored
        write = 1'b1;
        param = 3'b100;
        data_in = 22'h2AAAA;
        @(negedge clk);
        write = 1'b0;
        @(negedge clk);
        write = 1'b1;
        data_in = 22'h15555;
        @(negedge clk);
        write = 1'b0;
        @(negedge clk);
        chk("ovl_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("ovl_busy_fall", 32'(busy), 32'd0);
        chk("ovl_page", 32'(page_addr), 32'h2AAAA);
        @(negedge clk);
        chk("ovl_idle", 32'(busy), 32'd0);
        chk("ovl_page_keep", 32'(page_addr), 32'h2AAAA);

        // Write held high across the window is re-accepted in the first idle cycle
        write = 1'b1;
        param = 3'b011;
        data_in = 22'h000001;
        for (int i = 0; i <= int'(BC); i++) @(negedge clk);
        chk("held_busy_fall", 32'(busy), 32'd0);
        chk("held_wden", 32'(wd_en), 32'd1);
        @(negedge clk);
        chk("held_reaccept", 32'(busy), 32'd1);
        write = 1'b0;
        for (int i = 1; i < int'(BC); i++) @(negedge clk);
        @(negedge clk);
        chk("held_second_fall", 32'(busy), 32'd0);

        // Reset in the middle of a write
        write = 1'b1;
        param = 3'b100;
        data_in = 22'h3FFFFF;
        @(negedge clk);
        write = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_page", 32'(page_addr), 32'd0);
        chk("midrst_wdt", 32'(wd_timeout), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("midrst_no_valid", 32'(data_valid), 32'd0);
        release_and_startup();
        chk("midrst_page_after", 32'(page_addr), 32'd0);

        // reconfig beats a simultaneous write; request held by initiator
        write = 1'b1;
        reconfig = 1'b1;
        param = 3'b100;
        data_in = 22'h000001;
        @(negedge clk);
        write = 1'b0;
        chk("rc_busy", 32'(busy), 32'd1);
        chk("rc_req_low", 32'(reconfig_req), 32'd0);
        for (int i = 1; i < int'(RD); i++) begin
            @(negedge clk);
            chk("rc_wait", 32'({busy, reconfig_req}), 32'b10);
        end
        @(negedge clk);
        chk("rc_req", 32'(reconfig_req), 32'd1);
        for (int i = 0; i < 50; i++) begin
            write = 1'($urandom);
            read = 1'($urandom);
            reconfig = 1'($urandom);
            param = 3'($urandom);
            data_in = AW'($urandom);
            @(negedge clk);
            chk("done_sticky", 32'({busy, reconfig_req}), 32'b11);
        end
        chk("done_page", 32'(page_addr), 32'd0);
        chk("done_no_valid", 32'(data_valid), 32'd0);
        write = 1'b0;
        read = 1'b0;
        reconfig = 1'b0;

        // Reset clears the sticky request and restarts startup
        rst_n = 1'b0;
        #1;
        chk("rc_rst_clear", 32'(reconfig_req), 32'd0);
        @(negedge clk);
        release_and_startup();
        chk("rc_rst_req", 32'(reconfig_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
